// File: rtl/ahb_uart_pkg.sv
// Shared register offsets, bit positions and FSM encodings for the AHB-Lite UART.
package ahb_uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_VALID  = 2;
   localparam int ST_RX_FULL   = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_FRAME_ERR = 5;
   localparam int ST_TX_BUSY   = 6;

   localparam int CTRL_RX_IE  = 16;
   localparam int CTRL_TXE_IE = 17;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

   // Counter reload for the mid-start-bit check: (div+1)>>1 clocks total.
   function automatic logic [15:0] halfBit(input logic [15:0] div);
      logic [16:0] h;
      h = ({1'b0, div} + 17'd1) >> 1;
      return (h == 17'd0) ? 16'd0 : 16'(h - 17'd1);
   endfunction

endpackage

// File: rtl/ahb_uart_fifo.sv
// Synchronous FIFO; a push on a full FIFO succeeds only when a pop happens in the same cycle.
module ahb_uart_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, rdPtr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             doPush, doPop;

   assign doPop  = pop_i & (count_q != '0);
   assign doPush = push_i & ((count_q != CW'(DEPTH)) | doPop);

   always_comb begin
      count_d = count_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rdPtr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/ahb_uart_lite.sv
// AHB-Lite UART slave: 8N1 TX/RX with FIFOs, programmable divisor, sticky error flags.
// Define AHB_UART_IRQ_EN to implement CTRL[17:16] interrupt enables and the registered irq output.
module ahb_uart_lite
   import ahb_uart_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic        dphValid_q, dphWrite_q;
   logic [1:0]  dphAddr_q;
   logic [15:0] div_q;
   logic        overrun_q, frameErr_q;
   logic        wrEn, rdEn, txPush, rxPop, statusW1c, ctrlWr;
   logic        txFull, txEmpty, txPop, rxFull, rxEmpty, rxPushReq, frameErrSet;
   logic [7:0]  txFifoData, rxFifoData;
   logic [CW-1:0] unusedTxCount, unusedRxCount;
   logic [31:0] statusWord, ctrlWord;
   logic        unusedOk;

   txState_e    txState_q, txState_d;
   logic [15:0] txCnt_q, txCnt_d;
   logic [2:0]  txBit_q, txBit_d;
   logic [7:0]  txShift_q, txShift_d;
   logic        txOut_q, txOut_d;

   rxState_e    rxState_q, rxState_d;
   logic [15:0] rxCnt_q, rxCnt_d;
   logic [2:0]  rxBit_q, rxBit_d;
   logic [7:0]  rxShift_q, rxShift_d;
   logic        rxSync1_q, rxSync2_q, rxPrev_q;

   assign hreadyout = 1'b1;
   assign hresp     = 1'b0;
   assign unusedOk  = ^{haddr[31:4], haddr[1:0], hsize, hwdata, unusedTxCount, unusedRxCount};

   assign wrEn      = dphValid_q & dphWrite_q;
   assign rdEn      = dphValid_q & ~dphWrite_q;
   assign txPush    = wrEn & (dphAddr_q == REG_TXDATA);
   assign statusW1c = wrEn & (dphAddr_q == REG_STATUS);
   assign ctrlWr    = wrEn & (dphAddr_q == REG_CTRL);
   assign rxPop     = rdEn & (dphAddr_q == REG_RXDATA) & ~rxEmpty;

   ahb_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) txFifo (
      .clk(clk), .rst(rst), .push_i(txPush), .pop_i(txPop), .wdata_i(hwdata[7:0]),
      .rdata_o(txFifoData), .full_o(txFull), .empty_o(txEmpty), .count_o(unusedTxCount)
   );

   ahb_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) rxFifo (
      .clk(clk), .rst(rst), .push_i(rxPushReq), .pop_i(rxPop), .wdata_i(rxShift_q),
      .rdata_o(rxFifoData), .full_o(rxFull), .empty_o(rxEmpty), .count_o(unusedRxCount)
   );

   // Error flags: a new set in the same cycle as a W1C clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dphValid_q <= 1'b0;
         dphWrite_q <= 1'b0;
         dphAddr_q  <= 2'd0;
         div_q      <= DEFAULT_DIV;
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         dphValid_q <= hsel & htrans[1] & hready;
         if (hsel & htrans[1] & hready) begin
            dphWrite_q <= hwrite;
            dphAddr_q  <= haddr[3:2];
         end
         if (ctrlWr) div_q <= hwdata[15:0];
         overrun_q  <= (overrun_q & ~(statusW1c & hwdata[ST_OVERRUN]))
                       | (rxPushReq & rxFull & ~rxPop);
         frameErr_q <= (frameErr_q & ~(statusW1c & hwdata[ST_FRAME_ERR])) | frameErrSet;
      end
   end

`ifdef AHB_UART_IRQ_EN
   logic rxIe_q, txeIe_q, irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxIe_q  <= 1'b0;
         txeIe_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (ctrlWr) begin
            rxIe_q  <= hwdata[CTRL_RX_IE];
            txeIe_q <= hwdata[CTRL_TXE_IE];
         end
         irq_q <= (rxIe_q & ~rxEmpty) | (txeIe_q & txEmpty);
      end
   end

   assign irq      = irq_q;
   assign ctrlWord = {14'b0, txeIe_q, rxIe_q, div_q};
`else
   assign irq      = 1'b0;
   assign ctrlWord = {16'b0, div_q};
`endif

   assign statusWord = {25'b0, (txState_q != TX_IDLE), frameErr_q, overrun_q,
                        rxFull, ~rxEmpty, txEmpty, txFull};

   always_comb begin
      hrdata = 32'd0;
      if (rdEn) begin
         case (dphAddr_q)
            REG_TXDATA: hrdata = 32'd0;
            REG_RXDATA: hrdata = rxEmpty ? 32'd0 : {23'b0, 1'b1, rxFifoData};
            REG_STATUS: hrdata = statusWord;
            REG_CTRL:   hrdata = ctrlWord;
         endcase
      end
   end

   // TX engine: every bit lasts div_q+1 clocks, reloading the divisor at each bit boundary.
   always_comb begin
      txState_d = txState_q;
      txCnt_d   = txCnt_q;
      txBit_d   = txBit_q;
      txShift_d = txShift_q;
      txPop     = 1'b0;
      case (txState_q)
         TX_IDLE: begin
            if (!txEmpty) begin
               txState_d = TX_START;
               txPop     = 1'b1;
               txShift_d = txFifoData;
               txCnt_d   = div_q;
            end
         end
         TX_START: begin
            if (txCnt_q == 16'd0) begin
               txState_d = TX_DATA;
               txBit_d   = 3'd0;
               txCnt_d   = div_q;
            end else begin
               txCnt_d = txCnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (txCnt_q == 16'd0) begin
               txCnt_d   = div_q;
               txShift_d = txShift_q >> 1;
               if (txBit_q == 3'd7) txState_d = TX_STOP;
               else                 txBit_d   = txBit_q + 3'd1;
            end else begin
               txCnt_d = txCnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (txCnt_q == 16'd0) begin
               if (!txEmpty) begin
                  txState_d = TX_START;
                  txPop     = 1'b1;
                  txShift_d = txFifoData;
                  txCnt_d   = div_q;
               end else begin
                  txState_d = TX_IDLE;
               end
            end else begin
               txCnt_d = txCnt_q - 16'd1;
            end
         end
      endcase
      txOut_d = (txState_d == TX_START) ? 1'b0 :
                (txState_d == TX_DATA)  ? txShift_d[0] : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txState_q <= TX_IDLE;
         txCnt_q   <= 16'd0;
         txBit_q   <= 3'd0;
         txShift_q <= 8'd0;
         txOut_q   <= 1'b1;
      end else begin
         txState_q <= txState_d;
         txCnt_q   <= txCnt_d;
         txBit_q   <= txBit_d;
         txShift_q <= txShift_d;
         txOut_q   <= txOut_d;
      end
   end

   assign uart_tx = txOut_q;

   // RX engine: start detected on a synchronized falling edge, bits sampled mid-period.
   always_comb begin
      rxState_d   = rxState_q;
      rxCnt_d     = rxCnt_q;
      rxBit_d     = rxBit_q;
      rxShift_d   = rxShift_q;
      rxPushReq   = 1'b0;
      frameErrSet = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            if (!rxSync2_q && rxPrev_q) begin
               rxState_d = RX_START;
               rxCnt_d   = halfBit(div_q);
            end
         end
         RX_START: begin
            if (rxCnt_q == 16'd0) begin
               if (!rxSync2_q) begin
                  rxState_d = RX_DATA;
                  rxBit_d   = 3'd0;
                  rxCnt_d   = div_q;
               end else begin
                  rxState_d = RX_IDLE;
               end
            end else begin
               rxCnt_d = rxCnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (rxCnt_q == 16'd0) begin
               rxShift_d = {rxSync2_q, rxShift_q[7:1]};
               rxCnt_d   = div_q;
               if (rxBit_q == 3'd7) rxState_d = RX_STOP;
               else                 rxBit_d   = rxBit_q + 3'd1;
            end else begin
               rxCnt_d = rxCnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (rxCnt_q == 16'd0) begin
               rxState_d   = RX_IDLE;
               rxPushReq   = rxSync2_q;
               frameErrSet = ~rxSync2_q;
            end else begin
               rxCnt_d = rxCnt_q - 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxSync1_q <= 1'b1;
         rxSync2_q <= 1'b1;
         rxPrev_q  <= 1'b1;
         rxState_q <= RX_IDLE;
         rxCnt_q   <= 16'd0;
         rxBit_q   <= 3'd0;
         rxShift_q <= 8'd0;
      end else begin
         rxSync1_q <= uart_rx;
         rxSync2_q <= rxSync1_q;
         rxPrev_q  <= rxSync2_q;
         rxState_q <= rxState_d;
         rxCnt_q   <= rxCnt_d;
         rxBit_q   <= rxBit_d;
         rxShift_q <= rxShift_d;
      end
   end

endmodule

// File: tb/tb_ahb_uart_lite.sv
// Directed/randomized bench for ahb_uart_lite with a byte-level serial model and AHB register tasks.
// Builds with or without AHB_UART_IRQ_EN; the interrupt section follows the macro.
module tb_ahb_uart_lite;

   localparam int FIFO_DEPTH = 8;
   localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_CTRL = 4'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        uart_rx;
   logic        uart_tx;
   logic        irq;

   int testCount = 0;
   int failCount = 0;
   int tbDiv = 433;
   int txStopErrs = 0;
   logic [7:0] txSeen[$];

   ahb_uart_lite #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
      .hrdata(hrdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete AHB transfer: address phase, then data phase where read data is sampled.
   task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                                output logic [31:0] rd);
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = {28'h4000_000, addr}; hsize = 3'b010;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00; hwdata = wr ? data : 32'd0;
      rd = hrdata;
      @(posedge clk); #1;
   endtask

   task automatic regWrite(input logic [3:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      applyStimulus(1'b1, addr, data, dummy);
   endtask

   task automatic regRead(input logic [3:0] addr, output logic [31:0] data);
      applyStimulus(1'b0, addr, 32'd0, data);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      logic [9:0] bits;
      bits = {stopBit, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         uart_rx = bits[i];
         repeat (tbDiv + 1) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (4 * (tbDiv + 1)) @(negedge clk);
   endtask

   task automatic waitTxBytes(input int n, input string tag);
      int guard;
      guard = 0;
      while (txSeen.size() < n && guard < n * 12 * (tbDiv + 1) + 200) begin
         @(posedge clk);
         guard++;
      end
      checkOutput(tag, txSeen.size(), n);
   endtask

   // Serial decoder on uart_tx: sample each bit in its middle.
   initial begin : txMonitor
      logic [7:0] monByte;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0 && rst === 1'b0) begin
            repeat ((tbDiv + 1) / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (tbDiv + 1) @(negedge clk);
               monByte[i] = uart_tx;
            end
            repeat (tbDiv + 1) @(negedge clk);
            if (uart_tx !== 1'b1) txStopErrs++;
            txSeen.push_back(monByte);
         end
      end
   end

   initial begin : mainSeq
      logic [31:0] rd;
      logic [39:0] waveSeen, waveExp;
      logic [9:0]  frameBits;
      logic [7:0]  txBytes[10];
      logic [7:0]  rxModel[$];
      logic [7:0]  b;
      logic        overrunModel;
      logic [31:0] stExp;

      rst = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'b010; hwdata = 32'd0; hready = 1'b1; uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetTx", uart_tx, 1'b1);
      checkOutput("resetIrq", irq, 1'b0);
      checkOutput("resetHrdata", hrdata, 32'd0);
      checkOutput("resetReadyResp", {hreadyout, hresp}, 2'b10);
      @(negedge clk); rst = 1'b0;
      regRead(A_ST, rd);   checkOutput("resetStatus", rd, 32'h0000_0002);
      regRead(A_CTRL, rd); checkOutput("resetCtrl", rd, 32'h0000_01B1);

      tbDiv = 3;
      regWrite(A_CTRL, 32'd3);
      regRead(A_CTRL, rd); checkOutput("ctrlDiv3", rd, 32'd3);

      // 0xA5 frame: start, LSB-first data, stop, each held DIV+1 = 4 clocks.
      regWrite(A_TX, 32'h0000_00A5);
      checkOutput("txNotYetLow", uart_tx, 1'b1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         waveSeen[i] = uart_tx;
      end
      frameBits = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) waveExp[i] = frameBits[i / 4];
      checkOutput("txFallLatency", waveSeen[0], 1'b0);
      checkOutput("txA5Waveform", waveSeen, waveExp);
      repeat (2) @(posedge clk);
      regRead(A_ST, rd); checkOutput("statusAfterTx", rd, 32'h0000_0002);
      txSeen.delete();

      // Burst of 10 writes while busy: shifter plus FIFO hold FIFO_DEPTH+1, the rest is dropped.
      for (int i = 0; i < 10; i++) txBytes[i] = 8'($urandom);
      for (int i = 0; i < 10; i++) regWrite(A_TX, {24'd0, txBytes[i]});
      regRead(A_ST, rd); checkOutput("statusTxFullBusy", rd, 32'h0000_0041);
      waitTxBytes(FIFO_DEPTH + 1, "txBurstCount");
      for (int i = 0; i < FIFO_DEPTH + 1 && i < txSeen.size(); i++)
         checkOutput($sformatf("txBurstByte%0d", i), txSeen[i], txBytes[i]);
      repeat (100) @(posedge clk);
      checkOutput("txTenthDropped", txSeen.size(), FIFO_DEPTH + 1);
      regRead(A_ST, rd); checkOutput("statusTxDrained", rd, 32'h0000_0002);

      // Single received byte.
      sendFrame(8'h3C, 1'b1);
      regRead(A_ST, rd); checkOutput("statusRxValid", rd, 32'h0000_0006);
      regRead(A_RX, rd); checkOutput("rxData3C", rd, 32'h0000_013C);
      regRead(A_RX, rd); checkOutput("rxEmptyRead", rd, 32'h0000_0000);
      regRead(A_ST, rd); checkOutput("statusRxEmpty", rd, 32'h0000_0002);

      // Nine frames without reading: model keeps FIFO_DEPTH, flags overrun on the ninth.
      overrunModel = 1'b0;
      for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
         b = 8'($urandom);
         sendFrame(b, 1'b1);
         if (rxModel.size() < FIFO_DEPTH) rxModel.push_back(b);
         else                             overrunModel = 1'b1;
      end
      stExp = 32'h2 | ((rxModel.size() > 0) ? 32'h4 : 32'h0)
            | ((rxModel.size() == FIFO_DEPTH) ? 32'h8 : 32'h0) | (overrunModel ? 32'h10 : 32'h0);
      regRead(A_ST, rd); checkOutput("statusOverrun", rd, stExp);
      regWrite(A_ST, 32'h10);
      regRead(A_ST, rd); checkOutput("statusOverrunCleared", rd, stExp & ~32'h10);
      while (rxModel.size() > 0) begin
         regRead(A_RX, rd);
         checkOutput("rxFifoOrder", rd, {23'd0, 1'b1, rxModel.pop_front()});
      end
      regRead(A_ST, rd); checkOutput("statusRxDrained", rd, 32'h0000_0002);

      // Stop bit low: no push, sticky frame error, cleared by W1C.
      sendFrame(8'h55, 1'b0);
      regRead(A_ST, rd); checkOutput("statusFrameErr", rd, 32'h0000_0022);
      regWrite(A_ST, 32'h20);
      regRead(A_ST, rd); checkOutput("statusFrameErrCleared", rd, 32'h0000_0002);

      // Random divisor: both directions must follow the new bit period.
      tbDiv = $urandom_range(4, 12);
      regWrite(A_CTRL, tbDiv);
      regRead(A_CTRL, rd); checkOutput("ctrlRandomDiv", rd, tbDiv);
      b = 8'($urandom);
      sendFrame(b, 1'b1);
      regRead(A_RX, rd); checkOutput("rxRandomDiv", rd, {23'd0, 1'b1, b});
      txSeen.delete();
      b = 8'($urandom);
      regWrite(A_TX, {24'd0, b});
      waitTxBytes(1, "txRandomDivCount");
      if (txSeen.size() > 0) checkOutput("txRandomDivByte", txSeen[0], b);
      repeat (3 * (tbDiv + 1)) @(posedge clk);

`ifdef AHB_UART_IRQ_EN
      regWrite(A_CTRL, 32'h0001_0000 | tbDiv);
      regRead(A_CTRL, rd); checkOutput("ctrlRxIe", rd, 32'h0001_0000 | tbDiv);
      repeat (2) @(posedge clk); #1;
      checkOutput("irqIdle", irq, 1'b0);
      b = 8'($urandom);
      sendFrame(b, 1'b1);
      #1; checkOutput("irqRxValid", irq, 1'b1);
      regRead(A_RX, rd); checkOutput("rxIrqByte", rd, {23'd0, 1'b1, b});
      repeat (2) @(posedge clk); #1;
      checkOutput("irqRxCleared", irq, 1'b0);
      regWrite(A_CTRL, 32'h0002_0000 | tbDiv);
      repeat (2) @(posedge clk); #1;
      checkOutput("irqTxEmpty", irq, 1'b1);
      regWrite(A_CTRL, tbDiv);
      repeat (2) @(posedge clk); #1;
      checkOutput("irqDisabled", irq, 1'b0);
`else
      regWrite(A_CTRL, 32'h0003_0000 | tbDiv);
      regRead(A_CTRL, rd); checkOutput("ctrlIeIgnored", rd, tbDiv);
      b = 8'($urandom);
      sendFrame(b, 1'b1);
      #1; checkOutput("irqTiedLow", irq, 1'b0);
      regRead(A_RX, rd); checkOutput("rxNoIrqByte", rd, {23'd0, 1'b1, b});
`endif

      checkOutput("txStopBits", txStopErrs, 0);

      // Reset in the middle of a frame returns the line high without a clock edge.
      regWrite(A_TX, {24'd0, 8'($urandom)});
      @(posedge clk); #1;
      checkOutput("txMidFrameLow", uart_tx, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("txResetHigh", uart_tx, 1'b1);
      @(negedge clk); rst = 1'b0;
      tbDiv = 433;
      regRead(A_ST, rd);   checkOutput("statusAfterReset", rd, 32'h0000_0002);
      regRead(A_CTRL, rd); checkOutput("ctrlAfterReset", rd, 32'h0000_01B1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
